// File: rtl/iter_mul_writeback_if.sv
// Purpose: operand/handshake/write-port bundle between the control unit,
//          the register file and the iterative multiplier.
// Signals:
//   Start, OpA, OpB, DestIn           request side (driven by master)
//   Busy, Done, D, DA, En, Product    result side  (driven by slave)
interface iter_mul_writeback_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
);
    logic                  Start;
    logic [WIDTH-1:0]      OpA;
    logic [WIDTH-1:0]      OpB;
    logic [ADDR_W-1:0]     DestIn;
    logic                  Busy;
    logic                  Done;
    logic [WIDTH-1:0]      D;
    logic [ADDR_W-1:0]     DA;
    logic                  En;
    logic [2*WIDTH-1:0]    Product;

    modport master (
        output Start, OpA, OpB, DestIn,
        input  Busy, Done, D, DA, En, Product
    );

    modport slave (
        input  Start, OpA, OpB, DestIn,
        output Busy, Done, D, DA, En, Product
    );
endinterface

// File: rtl/iter_mul_writeback.sv
// Purpose: iterative unsigned shift-add multiplier that writes its product
//          back into the register file (low word to dest, optionally the
//          high word to dest+1), one multiply in flight at a time.
// Ports:
//   Clock  rising-edge clock
//   Reset  asynchronous active-high reset; aborts any multiply in flight
//   bus    iter_mul_writeback_if.slave: Start/OpA/OpB/DestIn in,
//          Busy/Done/D/DA/En/Product out (all registered)
module iter_mul_writeback #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned WRITE_HI = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    iter_mul_writeback_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        WB_LO = 2'd2,
        WB_HI = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplr_q,  mplr_d;   // low product half shifts in here
    logic [WIDTH-1:0]    acc_q,   acc_d;    // high product half
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [ADDR_W-1:0]   dest_q,  dest_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;
    logic                en_q,    en_d;
    logic [WIDTH-1:0]    d_q,     d_d;
    logic [ADDR_W-1:0]   da_q,    da_d;
    logic [2*WIDTH-1:0]  prod_q,  prod_d;
    logic [WIDTH:0]      sum;

    // State and datapath registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            dest_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            d_q     <= '0;
            da_q    <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            en_q    <= en_d;
            d_q     <= d_d;
            da_q    <= da_d;
            prod_q  <= prod_d;
        end
    end

    // Next-state, iteration datapath and registered-output values
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dest_d  = dest_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        en_d    = 1'b0;
        d_d     = d_q;
        da_d    = da_q;
        prod_d  = prod_q;

        // Extra bit keeps the carry so the shifted accumulator never truncates
        sum = {1'b0, acc_q} + {1'b0, mcand_q & {WIDTH{mplr_q[0]}}};

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    mcand_d = bus.OpA;
                    mplr_d  = bus.OpB;
                    dest_d  = bus.DestIn;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d  = sum[WIDTH:1];
                mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = WB_LO;
                end
            end
            WB_LO: begin
                en_d   = 1'b1;
                da_d   = dest_q;
                d_d    = mplr_q;
                prod_d = {acc_q, mplr_q};
                if (WRITE_HI != 0) begin
                    state_d = WB_HI;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            WB_HI: begin
                en_d    = 1'b1;
                da_d    = dest_q + ADDR_W'(1);   // register 31 wraps to 0
                d_d     = acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.En      = en_q;
    assign bus.D       = d_q;
    assign bus.DA      = da_q;
    assign bus.Product = prod_q;

endmodule
